// File: rtl/psk_out_reg.sv
// Output register stage of the PSK phase-accumulator handshake: realigns valid
// ROM addresses to ROM read latency and packs PACK samples per DAC word.
module psk_out_reg #(
    parameter int unsigned          DATA_W      = 12,
    parameter int unsigned          ROM_LATENCY = 2,
    parameter int unsigned          PACK        = 4,
    parameter int unsigned          READY_DELAY = 4,
    parameter logic [DATA_W-1:0]    IDLE_CODE   = 12'h800
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SIGN_START_CALC,
    input  logic                     SIGN_STOP_CALC,
    input  logic [DATA_W-1:0]        ROM_DATA,
    output logic                     OUT_REG_READY,
    output logic [PACK*DATA_W-1:0]   DAC_DATA,
    output logic                     DAC_VALID,
    output logic [31:0]              SAMPLE_COUNT,
    output logic                     GEN_DONE,
    output logic                     ERROR
);

    localparam int unsigned IDX_W = $clog2(PACK);
    localparam logic [PACK*DATA_W-1:0] IDLE_WORD = {PACK{IDLE_CODE}};

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_ARMED, S_GAP, S_STREAM, S_DRAIN, S_FLUSH
    } state_t;

    state_t                    state, state_nxt;
    logic                      start_prev;
    logic                      start_rise;
    logic                      addr_valid;
    logic [31:0]               tmr;
    logic [ROM_LATENCY-1:0]    vld_dly;
    logic                      cap;
    logic [IDX_W-1:0]          pack_idx;
    logic [DATA_W-1:0]         lanes [PACK];
    logic [PACK*DATA_W-1:0]    full_word;
    logic [PACK*DATA_W-1:0]    partial_word;

    assign start_rise = SIGN_START_CALC & ~start_prev;
    assign addr_valid = (state == S_STREAM);
    assign cap        = vld_dly[ROM_LATENCY-1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_rise) state_nxt = S_PREP;
            S_PREP:   if (tmr == READY_DELAY - 1) state_nxt = S_ARMED;
            S_ARMED:  if (!SIGN_START_CALC) state_nxt = S_GAP;
            S_GAP:    state_nxt = S_STREAM;
            S_STREAM: if (SIGN_STOP_CALC) state_nxt = S_DRAIN;
            S_DRAIN:  if (tmr == ROM_LATENCY - 1) state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The last lane comes straight from ROM_DATA so a word is registered on its capture edge.
    always_comb begin
        full_word    = '0;
        partial_word = '0;
        for (int unsigned j = 0; j < PACK; j++) begin
            full_word[j*DATA_W +: DATA_W]    = (j == PACK - 1) ? ROM_DATA : lanes[j];
            partial_word[j*DATA_W +: DATA_W] = (j < 32'(pack_idx)) ? lanes[j] : IDLE_CODE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            start_prev    <= 1'b1;
            tmr           <= '0;
            vld_dly       <= '0;
            pack_idx      <= '0;
            for (int unsigned i = 0; i < PACK; i++) lanes[i] <= IDLE_CODE;
            OUT_REG_READY <= 1'b0;
            DAC_DATA      <= IDLE_WORD;
            DAC_VALID     <= 1'b0;
            SAMPLE_COUNT  <= '0;
            GEN_DONE      <= 1'b0;
            ERROR         <= 1'b0;
        end else begin
            start_prev    <= SIGN_START_CALC;
            state         <= state_nxt;
            OUT_REG_READY <= (state_nxt == S_ARMED);
            DAC_VALID     <= 1'b0;
            GEN_DONE      <= 1'b0;
            vld_dly       <= (vld_dly << 1) | ROM_LATENCY'(addr_valid);

            if (state_nxt != state) tmr <= '0;
            else if (state == S_PREP || state == S_DRAIN) tmr <= tmr + 1'b1;

            if ((SIGN_STOP_CALC && state != S_STREAM) || (start_rise && state != S_IDLE))
                ERROR <= 1'b1;

            if (cap) begin
                lanes[pack_idx] <= ROM_DATA;
                if (SAMPLE_COUNT != '1) SAMPLE_COUNT <= SAMPLE_COUNT + 1'b1;
                if (pack_idx == IDX_W'(PACK - 1)) begin
                    pack_idx  <= '0;
                    DAC_DATA  <= full_word;
                    DAC_VALID <= 1'b1;
                end else begin
                    pack_idx <= pack_idx + 1'b1;
                end
            end

            case (state)
                S_IDLE, S_PREP, S_ARMED, S_GAP: DAC_DATA <= IDLE_WORD;
                S_FLUSH: begin
                    GEN_DONE <= 1'b1;
                    pack_idx <= '0;
                    if (pack_idx != '0) begin
                        DAC_DATA  <= partial_word;
                        DAC_VALID <= 1'b1;
                    end else begin
                        DAC_DATA  <= IDLE_WORD;
                    end
                end
                default: ;
            endcase

            if (state == S_IDLE && start_rise) begin
                SAMPLE_COUNT <= '0;
                pack_idx     <= '0;
                vld_dly      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psk_out_reg.sv
// Scoreboard bench for psk_out_reg: stimulus pushes expected DAC words and
// GEN_DONE cycles; a negedge monitor pops and compares them.
module tb_psk_out_reg;

    localparam logic [47:0] IDLE_W = 48'h800800800800;
    localparam logic [11:0] JUNK   = 12'hABC;

    logic        CLK = 1'b0;
    logic        RESET, START, STOP;
    logic [11:0] ROM_DATA, addr, rp1, rp2;
    logic        OUT_REG_READY, DAC_VALID, GEN_DONE, ERROR;
    logic [47:0] DAC_DATA;
    logic [31:0] SAMPLE_COUNT;

    psk_out_reg #(
        .DATA_W(12), .ROM_LATENCY(2), .PACK(4), .READY_DELAY(4), .IDLE_CODE(12'h800)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .SIGN_START_CALC(START), .SIGN_STOP_CALC(STOP),
        .ROM_DATA(ROM_DATA),
        .OUT_REG_READY(OUT_REG_READY), .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID),
        .SAMPLE_COUNT(SAMPLE_COUNT), .GEN_DONE(GEN_DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // ROM model: data equals address, two-cycle read latency.
    always @(posedge CLK) begin
        rp1 <= addr;
        rp2 <= rp1;
    end
    assign ROM_DATA = rp2;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] data;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        int   d;
        if (DAC_VALID === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_dac_valid", 64'(DAC_VALID), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("dac_data", DAC_DATA, e.data);
                check("dac_valid_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (GEN_DONE === 1'b1) begin
            if (done_q.size() == 0) check("unexpected_gen_done", 64'(GEN_DONE), 64'd0);
            else begin
                d = done_q.pop_front();
                check("gen_done_cycle", 64'(cyc), 64'(d));
            end
        end
    end

    function automatic logic [47:0] mkword(input int base, input int cnt);
        logic [47:0] w;
        w = IDLE_W;
        for (int j = 0; j < cnt; j++) w[j*12 +: 12] = 12'(base + j);
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // abort_at >= 0 asserts RESET in place of that stream sample.
    task automatic run_pkg(input int n, input bit inject, input int abort_at);
        int k_last;
        int t;
        k_last = 0;
        START = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("ready_low_in_prep", 64'(OUT_REG_READY), 64'd0);
        end
        check("dac_idle_in_prep", DAC_DATA, IDLE_W);
        tick();
        check("ready_high", 64'(OUT_REG_READY), 64'd1);
        if (inject) begin
            STOP = 1'b1;
            tick();
            STOP = 1'b0;
            check("error_stop_in_armed", 64'(ERROR), 64'd1);
        end else begin
            tick();
        end
        check("ready_hold", 64'(OUT_REG_READY), 64'd1);
        START = 1'b0;
        tick();
        check("ready_drop", 64'(OUT_REG_READY), 64'd0);
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                RESET = 1'b1;
                addr  = JUNK;
                STOP  = 1'b0;
                tick();
                RESET = 1'b0;
                repeat (10) tick();
                check("abort_sample_count", SAMPLE_COUNT, 64'd0);
                check("abort_ready", 64'(OUT_REG_READY), 64'd0);
                check("abort_error", 64'(ERROR), 64'd0);
                check("abort_dac_idle", DAC_DATA, IDLE_W);
                return;
            end
            addr = 12'(i);
            STOP = (i == n - 1);
            if (inject && i == 2) START = 1'b1;
            if (inject && i == 4) START = 1'b0;
            if (abort_at < 0 && (i % 4) == 3)
                exp_q.push_back('{data: mkword(i - 3, 4), at: cyc + 3});
            k_last = cyc;
            tick();
        end
        STOP = 1'b0;
        addr = JUNK;
        if ((n % 4) != 0)
            exp_q.push_back('{data: mkword(n - (n % 4), n % 4), at: k_last + 4});
        done_q.push_back(k_last + 4);
        t = 0;
        while ((exp_q.size() + done_q.size()) != 0 && t < 40) begin
            tick();
            t++;
        end
        check("pending_expectations", 64'(exp_q.size() + done_q.size()), 64'd0);
        exp_q.delete();
        done_q.delete();
        repeat (2) tick();
        check("sample_count", SAMPLE_COUNT, 64'(n));
        check("dac_idle_after", DAC_DATA, IDLE_W);
        check("dac_valid_low_after", 64'(DAC_VALID), 64'd0);
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b1;
        STOP  = 1'b0;
        addr  = JUNK;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (6) tick();
        check("reset_ready", 64'(OUT_REG_READY), 64'd0);
        check("reset_dac_data", DAC_DATA, IDLE_W);
        check("reset_dac_valid", 64'(DAC_VALID), 64'd0);
        check("reset_sample_count", SAMPLE_COUNT, 64'd0);
        check("reset_error", 64'(ERROR), 64'd0);
        START = 1'b0;
        repeat (2) tick();

        run_pkg(8, 1'b0, -1);
        check("clean8_error", 64'(ERROR), 64'd0);
        repeat (3) tick();
        run_pkg(6, 1'b0, -1);
        check("clean6_error", 64'(ERROR), 64'd0);
        repeat (3) tick();
        run_pkg(8, 1'b1, -1);
        check("error_sticky", 64'(ERROR), 64'd1);
        repeat (3) tick();
        run_pkg(8, 1'b0, 5);
        repeat (3) tick();
        run_pkg(8, 1'b0, -1);
        check("after_abort_error", 64'(ERROR), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
